avg_pool2x2: RTL and testbench
==============================

# avg_pool2x2

Streaming 2x2 average-pooling stage that sits directly downstream of the CNN convolution engine behind the Wishbone interconnect. It consumes one feature-map pixel per cycle in row-major order, for the default 8x8 frame. It emits a 4x4 pooled map, one result per 2x2 window, to the result buffer read back at 0x4000_0004 onward. A single line buffer holds partial sums from even rows, so no full-frame storage is needed.

## Interface
- IMG_W, 8, input frame width in pixels (even, >=2)
- IMG_H, 8, input frame height in pixels (even, >=2)
- DATA_W, 8, pixel width in bits (unsigned)
- clk  input  1  clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; arms a new frame when idle
- s_valid  input  1  upstream pixel valid
- s_data  input  DATA_W  upstream pixel
- s_ready  output  1  stage accepts pixel this cycle
- m_valid  output  1  pooled result valid
- m_data  output  DATA_W  pooled result
- m_ready  input  1  downstream accepts result
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse when the last pooled result is accepted

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start.
  - RUN -> DRAIN when the last input pixel (row IMG_H-1, col IMG_W-1) is accepted.
  - DRAIN -> IDLE when the final m_valid && m_ready occurs; done pulses in that same cycle.
- start is ignored outside IDLE.
- busy = (state != IDLE).
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance on each accepted pixel (s_valid && s_ready). col wraps to 0 and row increments at end of row.
- Pair register: on an even col, latch the pixel. On an odd col, pair_sum = latched + pixel, DATA_W+1 bits.
- Even row, odd col: linebuf[col>>1] <= pair_sum. The line buffer has IMG_W/2 entries of DATA_W+1 bits.
- Odd row, odd col: win_sum = linebuf[col>>1] + pair_sum, DATA_W+2 bits, no overflow possible. The output register is loaded with win_sum>>2 (truncation), and m_valid is set.
- Output register is one-deep:
  - m_valid clears on m_ready unless it is reloaded in the same cycle.
  - The same-cycle clear-and-reload case is legal and must not drop data.
- s_ready = (state == RUN) && (!m_valid || m_ready). Backpressure stalls input globally, not just on window-completing pixels.
- Reset (any time, including mid-frame):
  - state = IDLE; col, row, and the pair register cleared; m_valid=0, m_data=0, s_ready=0, busy=0, done=0.
  - Line buffer contents are don't-care. Every entry is rewritten on an even row before it is read.
- Pixels presented while in IDLE or DRAIN are not accepted (s_ready=0).

## Timing
- Output latency: m_valid asserts the cycle after the clock edge that accepts the window-completing pixel (row odd, col odd).
- Sustained throughput: 1 input pixel/cycle with m_ready held high; IMG_W*IMG_H/4 outputs per frame.
- done asserts the same cycle as the final output handshake and lasts one cycle. The earliest next start is accepted the following cycle.
- m_data holds its value while m_valid && !m_ready.
- Reset values of all outputs: 0.

## Configuration
- AVG_POOL_ROUND_EN defined: the result is (win_sum + 2) >> 2, round-half-up. The add uses DATA_W+2 bits; max (4*(2^DATA_W-1)+2)>>2 = 2^DATA_W-1, so no saturation is needed.
- AVG_POOL_ROUND_EN undefined: the result is win_sum >> 2, truncation. No rounding adder is instantiated.

## Test plan
- Ramp frame: pixels 0..63, m_ready=1.
  - Without the macro: outputs are 4,6,8,10,20,22,24,26,36,38,40,42,52,54,56,58.
  - With AVG_POOL_ROUND_EN: each of those values +1.
  - done pulses once, 16 outputs in total.
- Saturation frame: all 64 pixels = 255 -> 16 outputs of 255 in both builds. Check no overflow in win_sum (1020).
- Backpressure: drop m_ready for 10 cycles after the first output.
  - s_ready must be 0 during the stall.
  - m_data must hold 4.
  - The sequence must resume without loss or duplication.
- Reset mid-frame: assert rst after 20 accepted pixels.
  - All outputs go to 0 immediately and the state returns to IDLE.
  - A fresh start plus the ramp frame must yield the exact ramp results.
- Start while busy: pulse start during RUN and during DRAIN.
  - No effect on counters or outputs.
  - done pulses exactly once per frame.
- Back-to-back frames: issue start in the cycle after done, then send two ramp frames.
  - Must yield 32 correct outputs; the second frame must show no stale line-buffer data.

Source files
------------

// File: rtl/avg_pool2x2.sv
`default_nettype none
// ============================================================================
// Module   : avg_pool2x2
// Brief    : Streaming 2x2 average pooling with a single line buffer of
//            even-row pair sums. Define AVG_POOL_ROUND_EN for round-half-up.
// Revision : 1.0 - initial release
// ============================================================================
module avg_pool2x2 #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);

  localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int LB_AW = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;
  localparam int LB_D  = 1 << LB_AW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_row;
  logic [DATA_W-1:0]   r_pair;
  logic [DATA_W:0]     r_linebuf [LB_D];
  logic                r_m_valid;
  logic [DATA_W-1:0]   r_m_data;

  logic                w_accept;
  logic                w_last_col;
  logic                w_last_row;
  logic [LB_AW-1:0]    w_lb_idx;
  logic [DATA_W:0]     w_pair_sum;
  logic [DATA_W+1:0]   w_win_sum;
  logic [DATA_W-1:0]   w_result;
  logic                w_win_done;
  logic                w_lb_wr;

  assign s_ready    = (r_state == ST_RUN) && (!r_m_valid || m_ready);
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DRAIN) && r_m_valid && m_ready;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;

  assign w_accept   = s_valid && s_ready;
  assign w_last_col = (r_col == COL_W'(IMG_W - 1));
  assign w_last_row = (r_row == ROW_W'(IMG_H - 1));
  assign w_lb_idx   = LB_AW'(r_col >> 1);
  assign w_pair_sum = {1'b0, r_pair} + {1'b0, s_data};
  assign w_win_sum  = {1'b0, r_linebuf[w_lb_idx]} + {1'b0, w_pair_sum};
  assign w_win_done = w_accept && r_row[0] && r_col[0];
  assign w_lb_wr    = w_accept && !r_row[0] && r_col[0];

`ifdef AVG_POOL_ROUND_EN
  // Max 4*(2^DATA_W-1)+2 still fits DATA_W+2 bits, so no saturation.
  logic [DATA_W+1:0] w_win_rnd;
  assign w_win_rnd = w_win_sum + (DATA_W + 2)'(2);
  assign w_result  = DATA_W'(w_win_rnd >> 2);
`else
  assign w_result  = DATA_W'(w_win_sum >> 2);
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_accept && w_last_col && w_last_row) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (r_m_valid && m_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_col     <= '0;
      r_row     <= '0;
      r_pair    <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == ST_IDLE && start) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_accept) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end

      if (w_accept && !r_col[0]) r_pair <= s_data;

      // A reload can only coincide with a drain (s_ready gating), never overwrite.
      if (w_win_done) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_result;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  // Contents need no reset: every entry is rewritten on an even row before use.
  always_ff @(posedge clk) begin
    if (w_lb_wr) r_linebuf[w_lb_idx] <= w_pair_sum;
  end

endmodule
`default_nettype wire

// File: tb/tb_avg_pool2x2.sv
`default_nettype none
// ============================================================================
// Module   : tb_avg_pool2x2
// Brief    : Table-driven frame bench for avg_pool2x2 plus mid-frame reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avg_pool2x2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  avg_pool2x2 #(.IMG_W(8), .IMG_H(8), .DATA_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                base;
    int                step;
    int                stall;
    bit                noise;
    logic [0:15][7:0]  exp;
  } vec_t;

  vec_t tbl [6];

`ifdef AVG_POOL_ROUND_EN
  localparam logic [0:15][7:0] RAMP = {8'd5, 8'd7, 8'd9, 8'd11, 8'd21, 8'd23, 8'd25, 8'd27,
                                       8'd37, 8'd39, 8'd41, 8'd43, 8'd53, 8'd55, 8'd57, 8'd59};
`else
  localparam logic [0:15][7:0] RAMP = {8'd4, 8'd6, 8'd8, 8'd10, 8'd20, 8'd22, 8'd24, 8'd26,
                                       8'd36, 8'd38, 8'd40, 8'd42, 8'd52, 8'd54, 8'd56, 8'd58};
`endif
  localparam logic [0:15][7:0] SAT  = {16{8'd255}};
  localparam logic [0:15][7:0] OFS  = {8'd109, 8'd113, 8'd117, 8'd121, 8'd141, 8'd145, 8'd149, 8'd153,
                                       8'd173, 8'd177, 8'd181, 8'd185, 8'd205, 8'd209, 8'd213, 8'd217};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"},  m_data,  0);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_busy"},    busy,    0);
    chk({tag, "_done"},    done,    0);
  endtask

  // Streams one frame, starting the cycle the task is entered; abort_at>0 stops after that many pixels.
  task automatic run_frame(input vec_t v, input int abort_at);
    int pix = 0;
    int outs = 0;
    int cyc = 0;
    int stall_rem = 0;
    int dones = 0;
    bit stall_used = 0;
    while (outs < 16 && cyc < 3000 && !(abort_at > 0 && pix >= abort_at)) begin
      @(negedge clk);
      start   = (cyc == 0) || (v.noise && (pix == 30 || pix == 64));
      s_valid = (pix < 64);
      s_data  = 8'(v.base + v.step * pix);
      if (v.stall > 0 && !stall_used && m_valid) begin
        stall_rem  = v.stall;
        stall_used = 1;
      end
      m_ready = (stall_rem == 0);
      #1;
      if (cyc == 0) begin
        chk("idle_busy", busy, 0);
        chk("idle_s_ready", s_ready, 0);
      end
      if (stall_rem > 0) begin
        chk("stall_s_ready", s_ready, 0);
        chk("stall_hold", m_data, v.exp[0]);
        stall_rem--;
      end
      if (m_valid && m_ready && outs < 16) begin
        chk($sformatf("out%0d", outs), m_data, v.exp[outs]);
        chk($sformatf("done_at_out%0d", outs), done, (outs == 15));
        outs++;
      end
      if (done === 1'b1) dones++;
      if (s_valid && s_ready) pix++;
      cyc++;
    end
    start = 1'b0;
    if (abort_at > 0) return;
    chk("frame_outputs", outs, 16);
    chk("frame_pixels", pix, 64);
    chk("done_count", dones, 1);
  endtask

  initial begin
    tbl[0] = '{0,   1, 0,  1'b0, RAMP};
    tbl[1] = '{255, 0, 0,  1'b0, SAT};
    tbl[2] = '{0,   1, 10, 1'b0, RAMP};
    tbl[3] = '{0,   1, 0,  1'b1, RAMP};
    tbl[4] = '{100, 2, 0,  1'b0, OFS};
    tbl[5] = '{0,   1, 0,  1'b0, RAMP};

    rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_state("por");
    @(negedge clk);
    rst = 1'b1;

    // Frames run back-to-back: each start lands the cycle after the previous done.
    for (int i = 0; i < 6; i++) run_frame(tbl[i], 0);

    run_frame(tbl[0], 20);
    @(negedge clk);
    s_valid = 1'b1;
    m_ready = 1'b1;
    rst = 1'b0;
    #1;
    chk_reset_state("midrst");
    @(negedge clk);
    rst = 1'b1;
    run_frame(tbl[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule
`default_nettype wire
